// File: rtl/ext_pcpi_mac_core.sv
`default_nettype none
// ============================================================================
// ext_pcpi_mac_core : PCPI co-processor, iterative MUL / approximate MUL / MAC
// Revision: 1.0
// ============================================================================
module ext_pcpi_mac_core #(
    parameter int W     = 16,
    parameter int BPC   = 2,
    parameter int TRUNC = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pcpi_valid,
    input  logic [31:0] pcpi_insn,
    input  logic [31:0] pcpi_rs1,
    input  logic [31:0] pcpi_rs2,
    output logic        pcpi_wr,
    output logic [31:0] pcpi_rd,
    output logic        pcpi_wait,
    output logic        pcpi_ready
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_CALC   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [1:0] c_op_mul   = 2'd0;
    localparam logic [1:0] c_op_amul  = 2'd1;
    localparam logic [1:0] c_op_mac   = 2'd2;
    localparam logic [1:0] c_op_accrd = 2'd3;

    localparam int         c_steps      = W / BPC;
    localparam int         c_cnt_w      = $clog2(c_steps);
    localparam logic [W-1:0] c_trunc_mask = {W{1'b1}} << TRUNC;

    state_t             r_state;
    logic [1:0]         r_op;
    logic [2*W-1:0]     r_a;
    logic [W-1:0]       r_b;
    logic [2*W-1:0]     r_prod;
    logic [c_cnt_w-1:0] r_cnt;
    logic [31:0]        r_acc;

    logic               w_match;
    logic [W-1:0]       w_mask;
    logic [2*W-1:0]     w_step;
    logic [31:0]        w_p;
    logic [31:0]        w_mac_sum;
    logic               w_unused;

    assign w_match   = (pcpi_insn[6:0] == 7'b0001011) && (pcpi_insn[31:25] == 7'b0000001)
                       && !pcpi_insn[14];
    assign w_mask    = (pcpi_insn[13:12] == c_op_amul) ? c_trunc_mask : {W{1'b1}};
    assign w_p       = 32'(r_prod);
    assign w_mac_sum = r_acc + w_p;
    // Only the low operand bits and a few instruction fields matter.
    assign w_unused  = ^{pcpi_insn, pcpi_rs1, pcpi_rs2};

    // Partial product for the BPC multiplier bits retired this cycle.
    always_comb begin
        w_step = '0;
        for (int i = 0; i < BPC; i++) begin
            if (r_b[i]) begin
                w_step = w_step + (r_a << i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_op       <= c_op_mul;
            r_a        <= '0;
            r_b        <= '0;
            r_prod     <= '0;
            r_cnt      <= '0;
            r_acc      <= '0;
            pcpi_wr    <= 1'b0;
            pcpi_rd    <= '0;
            pcpi_wait  <= 1'b0;
            pcpi_ready <= 1'b0;
        end else begin
            pcpi_wr    <= 1'b0;
            pcpi_rd    <= '0;
            pcpi_ready <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (pcpi_valid) begin
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (pcpi_valid && w_match) begin
                        r_op      <= pcpi_insn[13:12];
                        r_a       <= {{W{1'b0}}, pcpi_rs1[W-1:0] & w_mask};
                        r_b       <= pcpi_rs2[W-1:0] & w_mask;
                        r_prod    <= '0;
                        r_cnt     <= c_cnt_w'(c_steps - 1);
                        pcpi_wait <= 1'b1;
                        r_state   <= (pcpi_insn[13:12] == c_op_accrd) ? S_DONE : S_CALC;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_CALC: begin
                    // Losing valid mid-operation abandons it without touching acc.
                    if (!pcpi_valid) begin
                        pcpi_wait <= 1'b0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_prod <= r_prod + w_step;
                        r_a    <= r_a << BPC;
                        r_b    <= r_b >> BPC;
                        if (r_cnt == '0) begin
                            r_state <= S_DONE;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    pcpi_wait  <= 1'b0;
                    pcpi_ready <= 1'b1;
                    pcpi_wr    <= 1'b1;
                    r_state    <= S_IDLE;
                    case (r_op)
                        c_op_mac: begin
                            r_acc   <= w_mac_sum;
                            pcpi_rd <= w_mac_sum;
                        end
                        c_op_accrd: begin
                            r_acc   <= '0;
                            pcpi_rd <= r_acc;
                        end
                        default: pcpi_rd <= w_p;
                    endcase
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ext_pcpi_mac_core.sv
`default_nettype none
// ============================================================================
// tb_ext_pcpi_mac_core : directed + random scoreboard bench for the MAC core
// Revision: 1.0
// ============================================================================
module tb_ext_pcpi_mac_core;

    logic        clk;
    logic        reset;
    logic        pcpi_valid;
    logic [31:0] pcpi_insn;
    logic [31:0] pcpi_rs1;
    logic [31:0] pcpi_rs2;
    logic        pcpi_wr;
    logic [31:0] pcpi_rd;
    logic        pcpi_wait;
    logic        pcpi_ready;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] m_acc = 32'h0;

    ext_pcpi_mac_core #(.W(16), .BPC(2), .TRUNC(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .pcpi_valid (pcpi_valid),
        .pcpi_insn  (pcpi_insn),
        .pcpi_rs1   (pcpi_rs1),
        .pcpi_rs2   (pcpi_rs2),
        .pcpi_wr    (pcpi_wr),
        .pcpi_rd    (pcpi_rd),
        .pcpi_wait  (pcpi_wait),
        .pcpi_ready (pcpi_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no end expected finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mk_insn(input logic [6:0] f7, input logic [2:0] f3);
        return {f7, 5'd2, 5'd1, f3, 5'd5, 7'b0001011};
    endfunction

    // Output monitor: every ready pulse must match the oldest expected result.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (pcpi_ready) begin
                checks++;
                assert (exp_q.size() > 0) else begin
                    errors++;
                    $error("FAIL unexpected_ready: observed ready=1 rd=%h expected no ready", pcpi_rd);
                end
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    checks++;
                    assert (pcpi_rd === e && pcpi_wr === 1'b1) else begin
                        errors++;
                        $error("FAIL result: observed rd=%h wr=%b expected rd=%h wr=1", pcpi_rd, pcpi_wr, e);
                    end
                end
            end else begin
                checks++;
                assert (pcpi_rd === 32'h0 && pcpi_wr === 1'b0) else begin
                    errors++;
                    $error("FAIL idle_outputs: observed rd=%h wr=%b expected rd=0 wr=0", pcpi_rd, pcpi_wr);
                end
            end
        end
    end

    // Issue one instruction starting in an IDLE cycle; returns in the cycle after ready.
    task automatic do_op(input logic [1:0] op, input logic [31:0] rs1, input logic [31:0] rs2);
        logic [31:0] a, b, p, e;
        int          lat, n, exp_lat;
        a = {16'h0, rs1[15:0]};
        b = {16'h0, rs2[15:0]};
        if (op == 2'd1) begin
            a = a & 32'hFFF0;
            b = b & 32'hFFF0;
        end
        p = a * b;
        case (op)
            2'd2: begin m_acc = m_acc + p; e = m_acc; end
            2'd3: begin e = m_acc; m_acc = 32'h0; end
            default: e = p;
        endcase
        exp_q.push_back(e);
        exp_lat = (op == 2'd3) ? 3 : 11;
        pcpi_valid = 1'b1;
        pcpi_insn  = mk_insn(7'b0000001, {1'b0, op});
        pcpi_rs1   = rs1;
        pcpi_rs2   = rs2;
        lat = 0;
        for (n = 1; n <= 40 && lat == 0; n++) begin
            @(posedge clk);
            #1;
            if (n == 2) begin
                pcpi_rs1 = $urandom;
                pcpi_rs2 = $urandom;
                checks++;
                assert (pcpi_wait === 1'b1) else begin
                    errors++;
                    $error("FAIL wait_busy: observed wait=%b expected 1", pcpi_wait);
                end
            end
            if (pcpi_ready === 1'b1) lat = n;
        end
        checks++;
        assert (lat == exp_lat && pcpi_wait === 1'b0) else begin
            errors++;
            $error("FAIL latency: observed %0d wait=%b expected %0d wait=0", lat, pcpi_wait, exp_lat);
        end
        pcpi_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic hold_nonmatch(input logic [31:0] insn);
        pcpi_valid = 1'b1;
        pcpi_insn  = insn;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            checks++;
            assert (pcpi_wait === 1'b0 && pcpi_ready === 1'b0 && pcpi_wr === 1'b0) else begin
                errors++;
                $error("FAIL nonmatch: observed wait=%b ready=%b wr=%b expected 0 0 0",
                       pcpi_wait, pcpi_ready, pcpi_wr);
            end
        end
        pcpi_valid = 1'b0;
        idle_cycles(2);
    endtask

    initial begin
        reset      = 1'b1;
        pcpi_valid = 1'b0;
        pcpi_insn  = 32'h0;
        pcpi_rs1   = 32'h0;
        pcpi_rs2   = 32'h0;
        idle_cycles(3);
        checks++;
        assert (pcpi_wait === 1'b0 && pcpi_ready === 1'b0 && pcpi_wr === 1'b0 && pcpi_rd === 32'h0)
        else begin
            errors++;
            $error("FAIL reset_state: observed wait=%b ready=%b wr=%b rd=%h expected all 0",
                   pcpi_wait, pcpi_ready, pcpi_wr, pcpi_rd);
        end
        reset = 1'b0;
        idle_cycles(1);

        do_op(2'd3, 32'h0, 32'h0);
        do_op(2'd0, 32'h00001234, 32'h00005678);
        do_op(2'd1, 32'h00001234, 32'h00005678);
        do_op(2'd0, 32'hABCD0003, 32'hFFFF0005);
        idle_cycles(2);
        do_op(2'd3, 32'h0, 32'h0);
        do_op(2'd2, 32'h0000FFFF, 32'h0000FFFF);
        do_op(2'd2, 32'h00000002, 32'h00000003);
        do_op(2'd3, 32'h0, 32'h0);
        do_op(2'd3, 32'h0, 32'h0);

        // MAC abandoned in its third CALC cycle must leave acc alone.
        do_op(2'd2, 32'h00000001, 32'h00000005);
        pcpi_valid = 1'b1;
        pcpi_insn  = mk_insn(7'b0000001, 3'b010);
        pcpi_rs1   = 32'h0000BEEF;
        pcpi_rs2   = 32'h0000CAFE;
        idle_cycles(4);
        pcpi_valid = 1'b0;
        idle_cycles(15);
        checks++;
        assert (pcpi_wait === 1'b0) else begin
            errors++;
            $error("FAIL abort_wait: observed wait=%b expected 0", pcpi_wait);
        end
        do_op(2'd3, 32'h0, 32'h0);

        // Reset in the middle of CALC discards the operation and clears acc.
        do_op(2'd2, 32'h00000007, 32'h00000009);
        pcpi_valid = 1'b1;
        pcpi_insn  = mk_insn(7'b0000001, 3'b010);
        pcpi_rs1   = 32'h00001111;
        pcpi_rs2   = 32'h00002222;
        idle_cycles(5);
        reset = 1'b1;
        idle_cycles(1);
        checks++;
        assert (pcpi_wait === 1'b0 && pcpi_ready === 1'b0 && pcpi_wr === 1'b0 && pcpi_rd === 32'h0)
        else begin
            errors++;
            $error("FAIL midcalc_reset: observed wait=%b ready=%b wr=%b rd=%h expected all 0",
                   pcpi_wait, pcpi_ready, pcpi_wr, pcpi_rd);
        end
        reset      = 1'b0;
        pcpi_valid = 1'b0;
        m_acc      = 32'h0;
        idle_cycles(15);
        do_op(2'd3, 32'h0, 32'h0);

        hold_nonmatch(mk_insn(7'b0000001, 3'b100));
        hold_nonmatch(mk_insn(7'b0000000, 3'b000));

        for (int i = 0; i < 8; i++) begin
            do_op(2'($urandom_range(0, 2)), $urandom, $urandom);
        end
        do_op(2'd3, 32'h0, 32'h0);
        idle_cycles(3);

        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain: observed %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ext_pcpi_mac_core.md
EXT_PCPI_MAC_CORE -- requirements
Module: ext_pcpi_mac_core

Interface
REQ-001 SHALL have parameter W, default 16: operand width used from rs1/rs2; legal 8..32.
REQ-002 SHALL have parameter BPC, default 2: multiplier bits retired per CALC cycle; legal 1, 2 or 4; W divisible by BPC.
REQ-003 SHALL have parameter TRUNC, default 4: number of operand LSBs zeroed in approximate mode; legal 0..W-1.
REQ-004 SHALL have one clock; reset is synchronous and active-high.
REQ-005 SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port pcpi_valid, input, 1, CPU offers an instruction.
REQ-008 SHALL have port pcpi_insn, input, 32, offered instruction word.
REQ-009 SHALL have port pcpi_rs1, input, 32, source operand 1.
REQ-010 SHALL have port pcpi_rs2, input, 32, source operand 2.
REQ-011 SHALL have port pcpi_wr, output reg, 1, write rd this cycle.
REQ-012 SHALL have port pcpi_rd, output reg, 32, result data.
REQ-013 SHALL have port pcpi_wait, output reg, 1, core has claimed the instruction and is busy.
REQ-014 SHALL have port pcpi_ready, output reg, 1, result valid, one-cycle pulse.

Function
REQ-015 SHALL claim only insn with [6:0]=0001011, [31:25]=0000001 and funct3 [14:12] in {000 MUL, 001 AMUL, 010 MAC, 011 ACCRD}; any other insn never asserts wait/ready/wr.
REQ-016 SHALL implement FSM IDLE -> DECODE -> CALC -> DONE -> IDLE; IDLE->DECODE when pcpi_valid=1; DECODE->CALC on matching MUL/AMUL/MAC, ->DONE on ACCRD, ->IDLE otherwise.
REQ-017 SHALL, in DECODE on a match, capture a=rs1[W-1:0], b=rs2[W-1:0] and the funct3; for AMUL zero a[TRUNC-1:0] and b[TRUNC-1:0] at capture.
REQ-018 SHALL compute the unsigned 2W-bit product iteratively by shift-add, BPC bits of b per cycle, CALC lasting exactly W/BPC cycles, then -> DONE.
REQ-019 SHALL define result P = product[31:0] (zero-extended when 2W<32).
REQ-020 SHALL hold a 32-bit accumulator acc: MAC sets acc <= acc+P (wraps mod 2^32) in DONE, rd = new acc; MUL/AMUL rd = P, acc unchanged; ACCRD rd = acc and acc <= 0 in DONE.
REQ-021 SHALL assert pcpi_wait from the cycle after DECODE match through the last DONE cycle's preceding cycle, i.e. while state is CALC or DONE is pending; deassert together with pcpi_ready rising.
REQ-022 SHALL drive pcpi_ready=1 and pcpi_wr=1 with pcpi_rd valid for exactly one cycle; pcpi_rd=0 in every other cycle.
REQ-023 SHALL have latency: ready asserted W/BPC+3 cycles after the first IDLE cycle with valid=1 (MUL/AMUL/MAC), 3 cycles for ACCRD.
REQ-024 SHALL abort to IDLE with no ready/wr and acc unchanged if pcpi_valid is 0 in any DECODE or CALC cycle.
REQ-025 SHALL ignore pcpi_rs1/rs2/insn changes after DECODE.
REQ-026 SHALL accept a new instruction in the IDLE cycle directly after DONE (back-to-back).

Reset
REQ-027 SHALL, with reset=1 at a clock edge, set state IDLE, acc=0, a=b=0, pcpi_wr=0, pcpi_rd=0, pcpi_wait=0, pcpi_ready=0, regardless of current state.
REQ-028 SHALL, on reset mid-CALC, discard the operation: no ready/wr afterwards, acc=0.

Verification (W=16, BPC=2, TRUNC=4)
REQ-029 SHALL cover MUL rs1=0x00001234, rs2=0x00005678 -> single ready/wr pulse with rd=0x06260060, 11 cycles after valid first seen.
REQ-030 SHALL cover AMUL same operands -> rd=0x06241500; MUL rs1=0xABCD0003, rs2=0xFFFF0005 -> rd=0x0000000F.
REQ-031 SHALL cover ACCRD, MAC 0xFFFF*0xFFFF -> rd=0xFFFE0001, MAC 0x0002*0x0003 -> rd=0xFFFE0007, ACCRD -> rd=0xFFFE0007, ACCRD -> rd=0x00000000.
REQ-032 SHALL cover pcpi_valid dropped in 3rd CALC cycle of MAC -> no ready/wr, following ACCRD returns prior acc unchanged.
REQ-033 SHALL cover reset asserted mid-CALC of MAC -> all outputs 0 next cycle, subsequent ACCRD rd=0x00000000.
REQ-034 SHALL cover insn funct3=100 and insn funct7=0000000 held valid 20 cycles -> wait, ready, wr stay 0.
